hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline hazard controller for the 5-stage core; it sits beside the ID stage and sequences the datapath around data and resource conflicts. It keeps its own scoreboard of in-flight destination registers (EX, DM) and drives the operand forwarding selects. It also drives the load-use stall/bubble, the taken-branch flush and the occupancy of the multi-cycle mult/div unit. All decisions are made for the instruction currently in ID.

## Interface
Parameters:
- MD_LATENCY, 4, cycles the mult/div unit is busy after issue (≥1)

Ports (reset rst_n is asynchronous, active-low; clock is clk):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global pipeline enable; 0 freezes all state
- id_req_a  in  5  source register A of ID instruction (0 = none)
- id_req_b  in  5  source register B of ID instruction (0 = none)
- id_req_w  in  5  destination register of ID instruction (0 = none)
- id_is_load  in  1  ID instruction is a load
- id_md_start  in  1  ID instruction is mult/div
- id_md_read  in  1  ID instruction reads HI/LO
- ex_branch_taken  in  1  branch in EX resolved taken
- fwd_a  out  2  operand A source: 00 regfile, 01 EX/DM result, 10 DM/WB result
- fwd_b  out  2  operand B source, same encoding
- stall_if  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX instead of ID instruction
- flush_id  out  1  discard the instruction in IF/ID
- md_busy  out  1  mult/div unit occupied

## Operation
- State: ex_w[4:0], ex_load, dm_w[4:0], md FSM {IDLE, BUSY}, md_cnt (width clog2(MD_LATENCY+1)).
- Match rule: a source matches a stage iff the stage dest ≠ 0 and the source equals it; register 0 never matches.
- Forwarding, per operand: EX match and !ex_load → 01; otherwise DM match → 10; otherwise 00. The EX match takes priority over the DM match.
- Load-use hazard: either operand matches EX and ex_load=1.
- MD hazard: FSM=BUSY and (id_md_start or id_md_read).
- Decision priority, per cycle:
  1. en=0: no state change. Outputs remain combinational on the held state.
  2. ex_branch_taken: flush_id=1 and bubble_ex=1; stall_if=0. Edge: ex_w←0, ex_load←0, dm_w←ex_w. No md issue.
  3. Load-use or MD hazard: stall_if=1 and bubble_ex=1. Edge: ex_w←0, ex_load←0, dm_w←ex_w. No md issue.
  4. Normal: ex_w←id_req_w, ex_load←id_is_load, dm_w←ex_w. If id_md_start, the md issue occurs.
- MD FSM:
  - Issue (only from IDLE): →BUSY, md_cnt←MD_LATENCY.
  - In BUSY, each en cycle decrements md_cnt. The edge on which md_cnt=1 returns the FSM to IDLE with md_cnt←0.
  - md_busy = (state==BUSY).
  - A taken branch does not abort a running mult/div.
- When stall_if=0 and no flush is active, fwd_a and fwd_b are valid for the ID instruction. During a stall they are don't-care for the datapath, but they must still follow the rule above.

## Timing
- Reset values: ex_w=0, ex_load=0, dm_w=0, FSM=IDLE, md_cnt=0.
  - Outputs under reset: fwd_a=fwd_b=00, stall_if=0, bubble_ex=0, md_busy=0.
  - flush_id follows ex_branch_taken combinationally, including during reset.
- Every output is combinational from state plus the current-cycle inputs; there are no registered outputs.
- A load-use stall lasts exactly 1 cycle. The next cycle the load sits in DM and the dependent operand gets fwd=10.
- An md issue at edge t holds md_busy high for MD_LATENCY cycles (excluding cycles with en=0). A dependent mfhi/mflo or mult/div in ID stalls for those cycles and proceeds on the first cycle with md_busy=0.
- Simultaneous events:
  - Flush with a hazard: flush wins, stall_if=0.
  - Load-use with MD hazard: a single combined stall.
  - en=0 with flush: hold, and flush_id is still asserted.
- Asserting rst_n mid-stall or mid-BUSY clears all state immediately (asynchronously).

## Test plan
- Back-to-back ALU dependency: ID writes r3, next ID reads r3 on A → fwd_a=01, no stall. The instruction after that reads r3 on B → fwd_b=10.
- Load-use: lw r5 in EX, ID reads r5 → stall_if=1 and bubble_ex=1 for exactly 1 cycle, then fwd=10 with stall_if=0.
- Register 0: writer with dest 0, then reader of r0 → fwd 00 and no stall, including when the writer is a load.
- MD: with MD_LATENCY=4, mult issued at edge t, mflo in ID at t+1 → stall_if=1 for cycles t+1..t+4, released at t+5. md_busy has the same window.
- Flush vs hazard: load-use hazard with ex_branch_taken=1 in the same cycle → flush_id=1, bubble_ex=1, stall_if=0. Next cycle ex_w=0.
- en=0 and reset: holding en=0 for 3 cycles during BUSY extends md_busy by 3 cycles. Pulsing rst_n low mid-BUSY → md_busy=0 and all fwd=00 immediately.

Source files
------------

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: ID-stage hazard controller for the 5-stage core.
// Tracks the destination registers in flight in EX and DM, selects operand
// forwarding, raises load-use / mult-div stalls, flushes on taken branches
// and sequences the occupancy of the multi-cycle mult/div unit.
module hazard_scheduler #(
    parameter int MD_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] id_req_a,
    input  logic [4:0] id_req_b,
    input  logic [4:0] id_req_w,
    input  logic       id_is_load,
    input  logic       id_md_start,
    input  logic       id_md_read,
    input  logic       ex_branch_taken,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       stall_if,
    output logic       bubble_ex,
    output logic       flush_id,
    output logic       md_busy
);

    localparam int CW = $clog2(MD_LATENCY + 1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    logic [4:0]    ex_w, ex_w_nxt;
    logic          ex_load, ex_load_nxt;
    logic [4:0]    dm_w, dm_w_nxt;
    md_state_t     md_state, md_state_nxt;
    logic [CW-1:0] md_cnt, md_cnt_nxt;

    logic a_ex, a_dm, b_ex, b_dm;
    logic load_use, md_hazard, hazard, md_issue;

    // Hazard detection and forwarding selects for the instruction in ID.
    // Register 0 never matches, so a dest of 0 behaves like "no writer".
    always_comb begin
        a_ex      = (ex_w != 5'd0) && (id_req_a == ex_w);
        b_ex      = (ex_w != 5'd0) && (id_req_b == ex_w);
        a_dm      = (dm_w != 5'd0) && (id_req_a == dm_w);
        b_dm      = (dm_w != 5'd0) && (id_req_b == dm_w);
        load_use  = ex_load && (a_ex || b_ex);
        md_hazard = (md_state == MD_BUSY) && (id_md_start || id_md_read);
        hazard    = load_use || md_hazard;
        md_issue  = !ex_branch_taken && !hazard && id_md_start;

        fwd_a = 2'b00;
        if (a_ex && !ex_load) fwd_a = 2'b01;
        else if (a_dm)        fwd_a = 2'b10;
        fwd_b = 2'b00;
        if (b_ex && !ex_load) fwd_b = 2'b01;
        else if (b_dm)        fwd_b = 2'b10;

        // A taken branch overrides any stall: the stalled instruction is
        // being discarded anyway.
        flush_id  = ex_branch_taken;
        bubble_ex = ex_branch_taken || hazard;
        stall_if  = !ex_branch_taken && hazard;
        md_busy   = (md_state == MD_BUSY);
    end

    // Next-state: pipeline scoreboard advance and mult/div occupancy FSM.
    always_comb begin
        ex_w_nxt     = ex_w;
        ex_load_nxt  = ex_load;
        dm_w_nxt     = dm_w;
        md_state_nxt = md_state;
        md_cnt_nxt   = md_cnt;
        if (en) begin
            dm_w_nxt = ex_w;
            if (ex_branch_taken || hazard) begin
                ex_w_nxt    = 5'd0;
                ex_load_nxt = 1'b0;
            end else begin
                ex_w_nxt    = id_req_w;
                ex_load_nxt = id_is_load;
            end
            case (md_state)
                MD_IDLE: begin
                    if (md_issue) begin
                        md_state_nxt = MD_BUSY;
                        md_cnt_nxt   = CW'(MD_LATENCY);
                    end
                end
                MD_BUSY: begin
                    // Branches do not abort a running mult/div.
                    if (md_cnt == CW'(1)) begin
                        md_state_nxt = MD_IDLE;
                        md_cnt_nxt   = '0;
                    end else begin
                        md_cnt_nxt = md_cnt - CW'(1);
                    end
                end
                default: begin
                    md_state_nxt = MD_IDLE;
                    md_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_w     <= 5'd0;
            ex_load  <= 1'b0;
            dm_w     <= 5'd0;
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            ex_w     <= ex_w_nxt;
            ex_load  <= ex_load_nxt;
            dm_w     <= dm_w_nxt;
            md_state <= md_state_nxt;
            md_cnt   <= md_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Testbench for hazard_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against an instruction-level pipeline model.
module tb_hazard_scheduler;

    localparam int MD_LAT = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] id_req_a, id_req_b, id_req_w;
    logic       id_is_load, id_md_start, id_md_read, ex_branch_taken;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_if, bubble_ex, flush_id, md_busy;

    hazard_scheduler #(.MD_LATENCY(MD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .id_req_a(id_req_a), .id_req_b(id_req_b), .id_req_w(id_req_w),
        .id_is_load(id_is_load), .id_md_start(id_md_start),
        .id_md_read(id_md_read), .ex_branch_taken(ex_branch_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if(stall_if),
        .bubble_ex(bubble_ex), .flush_id(flush_id), .md_busy(md_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    // model: which instruction sits in EX / DM, and mult/div cycles left
    int m_ex_w, m_dm_w, m_md_left;
    bit m_ex_load;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_fwd(input int src);
        if (src != 0 && src == m_ex_w && !m_ex_load) return 1;
        if (src != 0 && src == m_dm_w) return 2;
        return 0;
    endfunction

    function automatic bit m_hazard();
        bit lu, mh;
        lu = m_ex_load && ((id_req_a != 0 && int'(id_req_a) == m_ex_w) ||
                           (id_req_b != 0 && int'(id_req_b) == m_ex_w));
        mh = (m_md_left > 0) && (id_md_start || id_md_read);
        return lu || mh;
    endfunction

    // model advance on each clock edge, cleared by reset like the pipeline
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex_w = 0; m_ex_load = 0; m_dm_w = 0; m_md_left = 0;
        end else if (en) begin
            bit haz, issue;
            haz   = m_hazard();
            issue = !ex_branch_taken && !haz && id_md_start && (m_md_left == 0);
            if (m_md_left > 0) m_md_left--;
            if (issue) m_md_left = MD_LAT;
            m_dm_w = m_ex_w;
            if (ex_branch_taken || haz) begin
                m_ex_w = 0; m_ex_load = 0;
            end else begin
                m_ex_w = int'(id_req_w); m_ex_load = id_is_load;
            end
        end
    end

    // driver: present one ID cycle, then compare every output with the model
    task automatic step(input int a, input int b, input int w, input bit ld,
                        input bit ms, input bit mr, input bit br, input bit e);
        logic [7:0] exp_v, got_v;
        bit haz;
        @(negedge clk);
        id_req_a = 5'(a); id_req_b = 5'(b); id_req_w = 5'(w);
        id_is_load = ld; id_md_start = ms; id_md_read = mr;
        ex_branch_taken = br; en = e;
        #1;
        haz = m_hazard();
        exp_v = {2'(m_fwd(a)), 2'(m_fwd(b)), !br && haz, br || haz, br, m_md_left > 0};
        exp_q.push_back(exp_v);
        got_v = {fwd_a, fwd_b, stall_if, bubble_ex, flush_id, md_busy};
        exp_v = exp_q.pop_front();
        check("fwd_a",     8'(got_v[7:6]), 8'(exp_v[7:6]));
        check("fwd_b",     8'(got_v[5:4]), 8'(exp_v[5:4]));
        check("stall_if",  8'(got_v[3]),   8'(exp_v[3]));
        check("bubble_ex", 8'(got_v[2]),   8'(exp_v[2]));
        check("flush_id",  8'(got_v[1]),   8'(exp_v[1]));
        check("md_busy",   8'(got_v[0]),   8'(exp_v[0]));
    endtask

    initial begin
        int cnt_stall, cnt_busy;
        bit e;
        rst_n = 1'b0; en = 1'b1;
        id_req_a = '0; id_req_b = '0; id_req_w = '0;
        id_is_load = 0; id_md_start = 0; id_md_read = 0; ex_branch_taken = 0;

        // reset state, flush follows the branch input even in reset
        step(3, 4, 5, 1, 1, 0, 1, 1);
        check("rst_fwd_a", 8'(fwd_a), 8'd0);
        check("rst_stall", 8'(stall_if), 8'd0);
        check("rst_md_busy", 8'(md_busy), 8'd0);
        check("rst_flush", 8'(flush_id), 8'd1);
        rst_n = 1'b1;

        // back-to-back ALU dependency on r3
        step(0, 0, 3, 0, 0, 0, 0, 1);
        step(3, 0, 0, 0, 0, 0, 0, 1);
        check("alu_fwd_a_ex", 8'(fwd_a), 8'd1);
        check("alu_no_stall", 8'(stall_if), 8'd0);
        step(0, 3, 0, 0, 0, 0, 0, 1);
        check("alu_fwd_b_dm", 8'(fwd_b), 8'd2);

        // load-use on r5: one stall cycle, then forward from DM
        step(0, 0, 5, 1, 0, 0, 0, 1);
        step(5, 0, 6, 0, 0, 0, 0, 1);
        check("ld_stall", 8'(stall_if), 8'd1);
        check("ld_bubble", 8'(bubble_ex), 8'd1);
        step(5, 0, 6, 0, 0, 0, 0, 1);
        check("ld_release", 8'(stall_if), 8'd0);
        check("ld_fwd_dm", 8'(fwd_a), 8'd2);

        // register 0 never forwards or stalls, even behind a load
        step(0, 0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("r0_fwd", 8'(fwd_a), 8'd0);
        check("r0_stall", 8'(stall_if), 8'd0);

        // mult issued, mflo waits exactly MD_LAT cycles
        step(0, 0, 0, 0, 1, 0, 0, 1);
        check("md_issue_no_stall", 8'(stall_if), 8'd0);
        cnt_stall = 0; cnt_busy = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 1, 0, 1);
            if (md_busy) cnt_busy++;
            if (!stall_if) break;
            cnt_stall++;
        end
        check("md_stall_window", 8'(cnt_stall), 8'(MD_LAT));
        check("md_busy_window", 8'(cnt_busy), 8'(MD_LAT));

        // taken branch beats a load-use hazard; EX is emptied
        step(0, 0, 7, 1, 0, 0, 0, 1);
        step(7, 0, 0, 0, 0, 0, 1, 1);
        check("br_flush", 8'(flush_id), 8'd1);
        check("br_bubble", 8'(bubble_ex), 8'd1);
        check("br_no_stall", 8'(stall_if), 8'd0);
        step(7, 0, 0, 0, 0, 0, 0, 1);
        check("br_ex_cleared", 8'(stall_if), 8'd0);
        check("br_fwd_dm", 8'(fwd_a), 8'd2);

        // en=0 for 3 cycles during BUSY stretches md_busy by 3
        step(0, 0, 0, 0, 1, 0, 0, 1);
        cnt_busy = 0;
        for (int i = 0; i < 20; i++) begin
            e = !(i >= 1 && i <= 3);
            step(0, 0, 0, 0, 0, 0, 0, e);
            if (!md_busy) break;
            cnt_busy++;
        end
        check("md_en_hold_window", 8'(cnt_busy), 8'(MD_LAT + 3));

        // asynchronous reset in the middle of BUSY with live forwarding
        step(0, 0, 9, 0, 0, 0, 0, 1);
        step(0, 0, 10, 0, 1, 0, 0, 1);
        step(10, 9, 0, 0, 0, 0, 0, 1);
        check("pre_rst_busy", 8'(md_busy), 8'd1);
        check("pre_rst_fwd_a", 8'(fwd_a), 8'd1);
        check("pre_rst_fwd_b", 8'(fwd_b), 8'd2);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 8'(md_busy), 8'd0);
        check("async_rst_fwd_a", 8'(fwd_a), 8'd0);
        check("async_rst_fwd_b", 8'(fwd_b), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic over a small register set to force collisions
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
